// File: rtl/datapath_control_unit_pkg.sv
// Shared types and constants for the datapath control unit.
// CU_MULDIV_EN adds the mul/div opcodes to the legal instruction set.
package cu_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } cu_state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b01000;
  localparam logic [4:0] ALU_DIV  = 5'b01001;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  typedef struct packed {
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       MDRread;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       ZLOout;
    logic       ZHIout;
    logic       HIin;
    logic       LOin;
    logic       HIout;
    logic       LOout;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic       Cout;
    logic       CON_FF_In;
    logic       InPortout;
    logic       OPin;
    logic       wren;
    logic [4:0] ALUSelection;
  } ctl_t;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP,
      OP_HALT: return 1'b1;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Step on which each opcode finishes; stop is sampled there.
  function automatic cu_state_e last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST: return S_T7;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: return S_T5;
      OP_BR: return S_T6;
      OP_JAL: return S_T4;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: return S_T6;
`endif
      default: return S_T3;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB: return ALU_SUB;
      OP_AND: return ALU_AND;
      OP_OR:  return ALU_OR;
      OP_MUL: return ALU_MUL;
      OP_DIV: return ALU_DIV;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/datapath_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/flag/stop in, strobes and status out.
interface datapath_control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        stop;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, Yin, Zin;
  logic ZLOout, ZHIout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout;
  logic BAout, Cout, CON_FF_In, InPortout, OPin, wren;
  logic [4:0]  ALUSelection;
  logic        run;
  logic        illegal;

  modport master (
    input  IR, CON_FF, stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, Yin, Zin,
    output ZLOout, ZHIout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout,
    output BAout, Cout, CON_FF_In, InPortout, OPin, wren,
    output ALUSelection, run, illegal
  );

  modport slave (
    output IR, CON_FF, stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, Yin, Zin,
    input  ZLOout, ZHIout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout,
    input  BAout, Cout, CON_FF_In, InPortout, OPin, wren,
    input  ALUSelection, run, illegal
  );
endinterface

// File: rtl/datapath_control_unit_step_decoder.sv
// Pure combinational map (state, opcode, CON_FF) -> datapath strobe vector.
// CU_MULDIV_EN enables the mul/div execute sequence.
module cu_step_decoder
  import cu_pkg::*;
(
  input  cu_state_e  i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_con_ff,
  output ctl_t       o_ctl
);

  function automatic ctl_t exec_step(input cu_state_e st, input logic [4:0] op, input logic cf);
    ctl_t c;
    c = '0;
    case (op)
      OP_LD, OP_LDI, OP_ST: begin
        case (st)
          S_T3: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
          S_T4: begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUSelection = ALU_ADD; end
          S_T5: begin
            if (op == OP_LDI) begin
              c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
            end else begin
              c.ZLOout = 1'b1; c.MARin = 1'b1;
            end
          end
          S_T6: begin
            if (op == OP_LD) begin
              c.MDRread = 1'b1; c.MDRin = 1'b1;
            end else if (op == OP_ST) begin
              c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
            end else begin
              c = '0;
            end
          end
          S_T7: begin
            if (op == OP_LD) begin
              c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
            end else if (op == OP_ST) begin
              c.wren = 1'b1;
            end else begin
              c = '0;
            end
          end
          default: c = '0;
        endcase
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
        case (st)
          S_T3: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          S_T4: begin
            if (op == OP_ADDI) begin
              c.Cout = 1'b1;
            end else begin
              c.Grc = 1'b1; c.Rout = 1'b1;
            end
            c.Zin = 1'b1;
            c.ALUSelection = alu_code(op);
          end
          S_T5: begin c.ZLOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          default: c = '0;
        endcase
      end
      OP_BR: begin
        case (st)
          S_T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.CON_FF_In = 1'b1; end
          S_T4: begin c.PCout = 1'b1; c.Yin = 1'b1; end
          S_T5: begin c.Cout = 1'b1; c.Zin = 1'b1; c.ALUSelection = ALU_ADD; end
          S_T6: begin
            if (cf) begin
              c.ZLOout = 1'b1; c.PCin = 1'b1;
            end else begin
              c = '0;
            end
          end
          default: c = '0;
        endcase
      end
      OP_JR: begin
        if (st == S_T3) begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1;
        end else begin
          c = '0;
        end
      end
      OP_JAL: begin
        case (st)
          S_T3: begin c.PCout = 1'b1; c.Grb = 1'b1; c.Rin = 1'b1; end
          S_T4: begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
          default: c = '0;
        endcase
      end
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
        if (st == S_T3) begin
          c.Gra = 1'b1;
          c.InPortout = (op == OP_IN);
          c.HIout     = (op == OP_MFHI);
          c.LOout     = (op == OP_MFLO);
          c.OPin      = (op == OP_OUT);
          c.Rout      = (op == OP_OUT);
          c.Rin       = (op != OP_OUT);
        end else begin
          c = '0;
        end
      end
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: begin
        case (st)
          S_T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          S_T4: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.ALUSelection = alu_code(op); end
          S_T5: begin c.ZLOout = 1'b1; c.LOin = 1'b1; end
          S_T6: begin c.ZHIout = 1'b1; c.HIin = 1'b1; end
          default: c = '0;
        endcase
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Fetch is opcode-independent; execute steps decode the loaded IR.
  always_comb begin
    o_ctl = '0;
    case (i_state)
      S_T0: begin o_ctl.PCout = 1'b1; o_ctl.MARin = 1'b1; o_ctl.IncPC = 1'b1; o_ctl.Zin = 1'b1; end
      S_T1: begin o_ctl.ZLOout = 1'b1; o_ctl.PCin = 1'b1; o_ctl.MDRread = 1'b1; o_ctl.MDRin = 1'b1; end
      S_T2: begin o_ctl.MDRout = 1'b1; o_ctl.IRin = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: o_ctl = exec_step(i_state, i_opcode, i_con_ff);
      default: o_ctl = '0;
    endcase
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Hardwired Moore controller: state register, stop synchroniser, status outputs.
// Optional mul/div support via CU_MULDIV_EN (handled in package and step decoder).
module datapath_control_unit
  import cu_pkg::*;
#(
  parameter int PC_WIDTH  = 9,
  parameter int STOP_SYNC = 1
) (
  input logic                     clk,
  input logic                     clr,
  datapath_control_unit_if.master bus
);

  localparam bit SYNC_ON = (STOP_SYNC != 0) && (PC_WIDTH > 0);

  cu_state_e  r_state;
  cu_state_e  w_next;
  ctl_t       w_ctl;
  logic       w_stop;
  logic [4:0] w_opcode;
  logic       w_unused_ir;

  assign w_opcode    = bus.IR[OP_HI:OP_LO];
  assign w_unused_ir = &{1'b0, bus.IR[RA_HI:0]};

  if (SYNC_ON) begin : g_stop_sync
    logic [1:0] r_stop_sync;
    // Two-flop synchroniser for the asynchronous stop level.
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        r_stop_sync <= 2'b00;
      end else begin
        r_stop_sync <= {r_stop_sync[0], bus.stop};
      end
    end
    assign w_stop = r_stop_sync[1];
  end else begin : g_stop_direct
    assign w_stop = bus.stop;
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; stop is honoured only once the instruction finishes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0:  w_next = S_T1;
      S_T1:  w_next = S_T2;
      S_T2:  w_next = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if ((r_state == S_T3) && (w_opcode == OP_HALT)) begin
          w_next = S_HALT;
        end else if (r_state == last_step(w_opcode)) begin
          w_next = w_stop ? S_HALT : S_T0;
        end else begin
          w_next = cu_state_e'(r_state + 4'd1);
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  cu_step_decoder u_step_decoder (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_con_ff (bus.CON_FF),
    .o_ctl    (w_ctl)
  );

  // Output decode.
  always_comb begin
    {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.MDRread,
     bus.IRin, bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.HIin, bus.LOin,
     bus.HIout, bus.LOout, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
     bus.Cout, bus.CON_FF_In, bus.InPortout, bus.OPin, bus.wren, bus.ALUSelection} = w_ctl;
    bus.run     = (r_state != S_RST) && (r_state != S_HALT);
    bus.illegal = (r_state == S_T3) && !is_legal(w_opcode);
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: checks strobes and status per cycle.
module tb_datapath_control_unit;
  import cu_pkg::*;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errs;

  datapath_control_unit_if bus ();

  // stop is driven synchronously here, so the direct path is used.
  datapath_control_unit #(.PC_WIDTH(9), .STOP_SYNC(0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam ctl_t Z   = '0;
  localparam ctl_t F0  = '{PCout: 1'b1, MARin: 1'b1, IncPC: 1'b1, Zin: 1'b1, default: '0};
  localparam ctl_t F1  = '{ZLOout: 1'b1, PCin: 1'b1, MDRread: 1'b1, MDRin: 1'b1, default: '0};
  localparam ctl_t F2  = '{MDRout: 1'b1, IRin: 1'b1, default: '0};
  localparam ctl_t LD3 = '{Grb: 1'b1, BAout: 1'b1, Yin: 1'b1, default: '0};
  localparam ctl_t LD4 = '{Cout: 1'b1, Zin: 1'b1, ALUSelection: 5'b00001, default: '0};
  localparam ctl_t LD5 = '{ZLOout: 1'b1, MARin: 1'b1, default: '0};
  localparam ctl_t LD6 = '{MDRread: 1'b1, MDRin: 1'b1, default: '0};
  localparam ctl_t LD7 = '{MDRout: 1'b1, Gra: 1'b1, Rin: 1'b1, default: '0};
  localparam ctl_t RR3 = '{Grb: 1'b1, Rout: 1'b1, Yin: 1'b1, default: '0};
  localparam ctl_t WB5 = '{ZLOout: 1'b1, Gra: 1'b1, Rin: 1'b1, default: '0};

  function automatic ctl_t obs();
    return {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.MDRread,
            bus.IRin, bus.Yin, bus.Zin, bus.ZLOout, bus.ZHIout, bus.HIin, bus.LOin,
            bus.HIout, bus.LOout, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
            bus.Cout, bus.CON_FF_In, bus.InPortout, bus.OPin, bus.wren, bus.ALUSelection};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sample(input string tag, input ctl_t e, input logic run_e, input logic ill_e);
    check(tag, {30'd0, obs(), bus.run, bus.illegal}, {30'd0, e, run_e, ill_e});
  endtask

  task automatic step(input string tag, input ctl_t e, input logic run_e, input logic ill_e);
    @(negedge clk);
    sample(tag, e, run_e, ill_e);
  endtask

  task automatic fetch(input logic [31:0] ir);
    step("T0", F0, 1'b1, 1'b0);
    bus.IR = ir;
    step("T1", F1, 1'b1, 1'b0);
    step("T2", F2, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errs     = 0;
    clr        = 1'b1;
    bus.IR     = 32'h0000_0000;
    bus.CON_FF = 1'b0;
    bus.stop   = 1'b0;
    step("rst", Z, 1'b0, 1'b0);
    clr = 1'b0;

    // ld R2,0x44(R0)
    fetch(32'h0100_0044);
    step("ld_T3", LD3, 1'b1, 1'b0);
    step("ld_T4", LD4, 1'b1, 1'b0);
    step("ld_T5", LD5, 1'b1, 1'b0);
    step("ld_T6", LD6, 1'b1, 1'b0);
    step("ld_T7", LD7, 1'b1, 1'b0);

    // jal R2
    fetch(32'hA100_0000);
    step("jal_T3", '{PCout: 1'b1, Grb: 1'b1, Rin: 1'b1, default: '0}, 1'b1, 1'b0);
    step("jal_T4", '{Gra: 1'b1, Rout: 1'b1, PCin: 1'b1, default: '0}, 1'b1, 1'b0);

    // br, condition false then true
    for (int k = 0; k < 2; k++) begin
      bus.CON_FF = (k == 1);
      fetch(32'h9000_0000);
      step("br_T3", '{Gra: 1'b1, Rout: 1'b1, CON_FF_In: 1'b1, default: '0}, 1'b1, 1'b0);
      step("br_T4", '{PCout: 1'b1, Yin: 1'b1, default: '0}, 1'b1, 1'b0);
      step("br_T5", LD4, 1'b1, 1'b0);
      if (k == 1) begin
        step("br_T6_taken", '{ZLOout: 1'b1, PCin: 1'b1, default: '0}, 1'b1, 1'b0);
      end else begin
        step("br_T6_not", Z, 1'b1, 1'b0);
      end
    end
    bus.CON_FF = 1'b0;

    // st
    fetch(32'h1000_0000);
    step("st_T3", LD3, 1'b1, 1'b0);
    step("st_T4", LD4, 1'b1, 1'b0);
    step("st_T5", LD5, 1'b1, 1'b0);
    step("st_T6", '{Gra: 1'b1, Rout: 1'b1, MDRin: 1'b1, default: '0}, 1'b1, 1'b0);
    step("st_T7", '{wren: 1'b1, default: '0}, 1'b1, 1'b0);

    // sub
    fetch(32'h2000_0000);
    step("sub_T3", RR3, 1'b1, 1'b0);
    step("sub_T4", '{Grc: 1'b1, Rout: 1'b1, Zin: 1'b1, ALUSelection: 5'b00010, default: '0}, 1'b1, 1'b0);
    step("sub_T5", WB5, 1'b1, 1'b0);

    // undefined opcode 11111
    fetch(32'hF800_0000);
    step("ill_T3", Z, 1'b1, 1'b1);

`ifndef CU_MULDIV_EN
    fetch(32'h7000_0000);
    step("mul_ill_T3", Z, 1'b1, 1'b1);
`else
    fetch(32'h7000_0000);
    step("mul_T3", '{Gra: 1'b1, Rout: 1'b1, Yin: 1'b1, default: '0}, 1'b1, 1'b0);
    step("mul_T4", '{Grb: 1'b1, Rout: 1'b1, Zin: 1'b1, ALUSelection: 5'b01000, default: '0}, 1'b1, 1'b0);
    step("mul_T5", '{ZLOout: 1'b1, LOin: 1'b1, default: '0}, 1'b1, 1'b0);
    step("mul_T6", '{ZHIout: 1'b1, HIin: 1'b1, default: '0}, 1'b1, 1'b0);
`endif

    // add with stop raised during T4
    fetch(32'h1800_0000);
    step("add_T3", RR3, 1'b1, 1'b0);
    step("add_T4", '{Grc: 1'b1, Rout: 1'b1, Zin: 1'b1, ALUSelection: 5'b00001, default: '0}, 1'b1, 1'b0);
    bus.stop = 1'b1;
    step("add_T5", WB5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("halt_hold", Z, 1'b0, 1'b0);
    end
    bus.stop = 1'b0;

    clr = 1'b1;
    step("rst2", Z, 1'b0, 1'b0);
    clr = 1'b0;

    // ld aborted by asynchronous clr in T5
    fetch(32'h0100_0044);
    step("ld2_T3", LD3, 1'b1, 1'b0);
    step("ld2_T4", LD4, 1'b1, 1'b0);
    step("ld2_T5", LD5, 1'b1, 1'b0);
    #2 clr = 1'b1;
    #1 sample("abort", Z, 1'b0, 1'b0);
    #1 clr = 1'b0;

    // halt opcode
    fetch(32'hD000_0000);
    step("halt_T3", Z, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("halt_op", Z, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/datapath_control_unit.md
Name: datapath_control_unit

Overview:
- Hardwired Moore controller that sequences CPU_Datapath through fetch (T0-T2) and per-opcode execute steps (T3-T7).
- Replaces hand-driven control stimulus. Consumes IR and CON_FF_Out; drives every datapath control strobe.
- Sits between the datapath and the top level. Exposes run/halt status.

Parameters:
- PC_WIDTH, 9, width of MAR/PC address space (informational, matches testMAR width; no logic depends on it beyond documentation)
- STOP_SYNC, 1, 1 = stop input passes through a 2-flop synchroniser; 0 = used directly

Ports:
- clk  in  1  system clock, all state changes on posedge
- clr  in  1  asynchronous active-high reset
- IR  in  32  instruction register contents; opcode IR[31:27]
- CON_FF  in  1  branch-condition flag from datapath
- stop  in  1  halt request, level
- PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin, Yin, Zin, ZLOout, ZHIout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CON_FF_In, InPortout, OPin, wren  out  1 each  datapath strobes
- ALUSelection  out  5  ALU operation code
- run  out  1  1 while executing, 0 in HALT
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- State register: RST, T0-T7, HALT. All outputs are combinational decode of (state, IR opcode) and are valid for the whole cycle. The datapath samples them on the following posedge.
- Reset (clr=1, async): state=RST immediately. All strobes 0, ALUSelection=0, illegal=0, run=0. Mid-instruction reset aborts with no further strobes.
- RST -> T0 on the first clk after clr drops; run=1 from T0.
- Fetch, common to all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, MDRread, MDRin.
  - T2: MDRout, IRin. T3 decodes the newly loaded IR.
- Execute, one step per cycle. The last listed step returns to T0:
  - ld 00000: T3 Grb BAout Yin; T4 Cout Zin ALU_ADD; T5 ZLOout MARin; T6 MDRread MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout Zin ALU_ADD; T5 ZLOout Gra Rin.
  - st 00010: T3-T5 as ld; T6 Gra Rout MDRin (MDRread=0); T7 wren.
  - add 00011 / sub 00100 / and 01001 / or 01010: T3 Grb Rout Yin; T4 Grc Rout Zin ALU_op; T5 ZLOout Gra Rin.
  - addi 01011: T3 Grb Rout Yin; T4 Cout Zin ALU_ADD; T5 ZLOout Gra Rin.
  - br 10010: T3 Gra Rout CON_FF_In; T4 PCout Yin; T5 Cout Zin ALU_ADD; T6 ZLOout and PCin only if CON_FF=1, otherwise T6 asserts nothing.
  - jr 10011: T3 Gra Rout PCin.
  - jal 10100: T3 PCout Grb Rin; T4 Gra Rout PCin.
  - in 10101: T3 InPortout Gra Rin. out 10110: T3 Gra Rout OPin.
  - mfhi 10111: T3 HIout Gra Rin. mflo 11000: T3 LOout Gra Rin.
  - nop 11001: T3 idle.
  - halt 11010: T3 -> HALT.
- Undefined opcode: behaves as nop; illegal=1 during T3 only.
- HALT: all strobes 0, run=0. Held until clr.
- stop: checked on the final execute step. If stop=1, go to HALT instead of T0. An in-flight instruction always completes.
- Strobes are never asserted outside the listed steps. No two bus drivers (*out, Rout, Cout, BAout excepted with Grb) are active in the same cycle.

Optional Feature:
- Macro CU_MULDIV_EN.
- Defined: mul 01110 and div 01111 execute T3 Gra Rout Yin; T4 Grb Rout Zin ALU_MUL/ALU_DIV; T5 ZLOout LOin; T6 ZHIout HIin.
- Undefined: those opcodes are illegal (nop plus illegal pulse).

Decomposition:
- Package cu_pkg holds the state enum, the 5-bit opcode constants, the ALU codes (ALU_ADD 00001, ALU_SUB 00010, ALU_AND 00011, ALU_OR 00100, ALU_MUL 01000, ALU_DIV 01001) and the IR field positions (Ra 26:23, Rb 22:19, Rc 18:15).
- One sub-module, cu_step_decoder: purely combinational (state, opcode, CON_FF) -> strobe vector. The top level holds the state register, stop synchroniser and illegal pulse.

Test Plan:
- Reset then release, memory word 0x01000044 (ld R2,0x44(R0)) -> T0..T7 sequence matches ld steps exactly; T7 has MDRout=Gra=Rin=1; back to T0 next cycle.
- IR=0xA1000000 (jal R2) -> T3 PCout=Grb=Rin=1, T4 Gra=Rout=PCin=1, then T0; total 5 cycles.
- br with CON_FF=0 then CON_FF=1 -> PCin low in T6 for the first, high in T6 for the second.
- IR opcode 11111 -> illegal=1 for exactly the T3 cycle; no strobes; next state T0.
- stop raised during T4 of add -> T5 completes, next state HALT, run=0; all strobes 0 for 10 cycles.
- clr pulsed mid-T5 of ld (asynchronously, between edges) -> strobes drop to 0 within the same timestep; restart at T0 after release.
